// File: rtl/mc_control_pkg.sv
// ============================================================================
// Module   : mc_control_pkg
// Brief    : Shared state, opcode/funct and ALU function-code definitions.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mc_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BREX    = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  // Which decode rule the ALU code is taken from in the current state.
  typedef enum logic [2:0] {
    ACLS_NONE  = 3'd0,
    ACLS_ADD   = 3'd1,
    ACLS_SUB   = 3'd2,
    ACLS_RTYPE = 3'd3,
    ACLS_IMM   = 3'd4
  } alu_class_t;

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_j     = 6'b000010;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_bne   = 6'b000101;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_slti  = 6'b001010;
  localparam logic [5:0] c_op_andi  = 6'b001100;
  localparam logic [5:0] c_op_ori   = 6'b001101;
  localparam logic [5:0] c_op_xori  = 6'b001110;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;

  localparam logic [5:0] c_fn_add   = 6'b100000;
  localparam logic [5:0] c_fn_addu  = 6'b100001;
  localparam logic [5:0] c_fn_sub   = 6'b100010;
  localparam logic [5:0] c_fn_subu  = 6'b100011;
  localparam logic [5:0] c_fn_and   = 6'b100100;
  localparam logic [5:0] c_fn_or    = 6'b100101;
  localparam logic [5:0] c_fn_xor   = 6'b100110;
  localparam logic [5:0] c_fn_slt   = 6'b101010;
  localparam logic [5:0] c_fn_sltu  = 6'b101011;

  // Bit 3 = invert B with carry-in, bits 2:0 = op select.
  localparam logic [3:0] c_alu_and  = 4'b0000;
  localparam logic [3:0] c_alu_or   = 4'b0001;
  localparam logic [3:0] c_alu_add  = 4'b0010;
  localparam logic [3:0] c_alu_xor  = 4'b0101;
  localparam logic [3:0] c_alu_sub  = 4'b1010;
  localparam logic [3:0] c_alu_slt  = 4'b1011;

endpackage

`default_nettype wire

// File: rtl/mc_control_alu_dec.sv
// ============================================================================
// Module   : alu_dec
// Brief    : Maps (state class, op, funct) to the ALU function code.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_dec
  import mc_control_pkg::*;
(
  input  alu_class_t  aclass,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  output logic [3:0]  alucontrol,
  output logic        funct_ok
);

  always_comb begin
    alucontrol = c_alu_and;
    funct_ok   = 1'b0;
    case (aclass)
      ACLS_ADD: alucontrol = c_alu_add;
      ACLS_SUB: alucontrol = c_alu_sub;
      ACLS_RTYPE: begin
        funct_ok = 1'b1;
        case (funct)
          c_fn_add, c_fn_addu: alucontrol = c_alu_add;
          c_fn_sub, c_fn_subu: alucontrol = c_alu_sub;
          c_fn_and:            alucontrol = c_alu_and;
          c_fn_or:             alucontrol = c_alu_or;
          c_fn_xor:            alucontrol = c_alu_xor;
          c_fn_slt, c_fn_sltu: alucontrol = c_alu_slt;
          default: begin
            alucontrol = c_alu_add;
            funct_ok   = 1'b0;
          end
        endcase
      end
      ACLS_IMM: begin
        case (op)
          c_op_slti: alucontrol = c_alu_slt;
          c_op_andi: alucontrol = c_alu_and;
          c_op_ori:  alucontrol = c_alu_or;
          c_op_xori: alucontrol = c_alu_xor;
          default:   alucontrol = c_alu_add;
        endcase
      end
      default: alucontrol = c_alu_and;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_control.sv
// ============================================================================
// Module   : mc_control
// Brief    : Multicycle control FSM for the 32-bit datapath with mem_ready.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mc_control
  import mc_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [3:0] alucontrol
);

  state_t     r_state;
  state_t     w_next;
  alu_class_t w_aclass;
  logic       w_funct_ok;
  logic       w_irwrite;
  logic       w_memwrite;
  logic       w_regwrite;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_is_bne;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Kept apart from the next-state block: the funct check feeds back into it.
  always_comb begin
    w_aclass = ACLS_NONE;
    case (r_state)
      S_FETCH, S_DECODE, S_MEMADR: w_aclass = ACLS_ADD;
      S_BREX:                      w_aclass = ACLS_SUB;
      S_RTYPEEX:                   w_aclass = ACLS_RTYPE;
      S_IMMEX:                     w_aclass = ACLS_IMM;
      default:                     w_aclass = ACLS_NONE;
    endcase
  end

  alu_dec u_alu_dec (
    .aclass     (w_aclass),
    .op         (op),
    .funct      (funct),
    .alucontrol (alucontrol),
    .funct_ok   (w_funct_ok)
  );

  always_comb begin
    w_next     = r_state;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    w_irwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    case (r_state)
      S_FETCH: begin
        alusrcb   = 2'b01;
        w_irwrite = mem_ready;
        w_pcwrite = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          c_op_lw, c_op_sw:     w_next = S_MEMADR;
          c_op_rtype:           w_next = S_RTYPEEX;
          c_op_beq, c_op_bne:   w_next = S_BREX;
          c_op_addi, c_op_slti, c_op_andi,
          c_op_ori, c_op_xori:  w_next = S_IMMEX;
          c_op_j:               w_next = S_JEX;
          default:              w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = (op == c_op_sw) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        w_memwrite = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        w_next  = w_funct_ok ? S_RTYPEWB : S_FETCH;
      end
      S_RTYPEWB: begin
        regdst     = 1'b1;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_BREX: begin
        alusrca  = 1'b1;
        pcsrc    = 2'b01;
        w_branch = 1'b1;
        w_next   = S_FETCH;
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = S_IMMWB;
      end
      S_IMMWB: begin
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_JEX: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
        w_next    = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign w_is_bne = (op == c_op_bne);

  // Enables are masked by reset so nothing is written while rst_n is low.
  assign irwrite  = w_irwrite  & rst_n;
  assign memwrite = w_memwrite & rst_n;
  assign regwrite = w_regwrite & rst_n;
  assign pcen     = rst_n & (w_pcwrite | (w_branch & (zero ^ w_is_bne)));

endmodule

`default_nettype wire

// File: doc/mc_control.md
# mc_control

Multicycle control unit that sequences instruction execution for the 32-bit datapath and drives the ALU's 4-bit function code. It decodes the latched opcode/funct into the ALU's encoding (bit 3 = invert B with carry-in, bits 2:0 = op select) and consumes the ALU's `zero` flag for branches. It sits between instruction register and datapath, with a `mem_ready` handshake so memory may take any number of cycles.

## Interface

Parameters: none.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous reset, active low.
- `op` input 6: opcode from instruction register, stable after DECODE.
- `funct` input 6: funct field from instruction register.
- `zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory access completes this cycle.
- `iord` output 1: memory address = ALU result register (1) or PC (0).
- `memwrite` output 1: memory write strobe.
- `irwrite` output 1: instruction register load.
- `regdst` output 1: write register = rd (1) or rt (0).
- `memtoreg` output 1: register write data = memory data (1) or ALU result register (0).
- `regwrite` output 1: register file write.
- `alusrca` output 1: ALU A = register A (1) or PC (0).
- `alusrcb` output 2: 00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- `pcsrc` output 2: 00 ALU out, 01 ALU result register, 10 jump target.
- `pcen` output 1: PC load = `pcwrite | (branch & (zero ^ is_bne))`.
- `alucontrol` output 4: ALU function code.

## Operation

- ALU codes: AND 0000, OR 0001, ADD 0010, SLT 1011, SUB 1010, XOR 0101.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BREX, IMMEX, IMMWB, JEX.
- FETCH: `iord`=0, `alusrca`=0, `alusrcb`=01, `alucontrol`=ADD, `pcsrc`=00. `irwrite` and `pcwrite` equal `mem_ready`. Stay in FETCH until `mem_ready`, then go to DECODE.
- DECODE: `alusrcb`=11, ADD (branch target). Next state by op:
  - lw 100011 / sw 101011 -> MEMADR.
  - R-type 000000 -> RTYPEEX.
  - beq 000100 / bne 000101 -> BREX.
  - addi 001000, slti 001010, andi 001100, ori 001101, xori 001110 -> IMMEX.
  - j 000010 -> JEX.
  - Any other op -> FETCH (no-op; no write enables).
- MEMADR: `alusrca`=1, `alusrcb`=10, ADD. Next MEMRD (lw) or MEMWR (sw).
- MEMRD: `iord`=1; wait for `mem_ready`, then MEMWB.
- MEMWB: `regdst`=0, `memtoreg`=1, `regwrite`=1; next FETCH.
- MEMWR: `iord`=1, `memwrite`=1; hold until `mem_ready`, then FETCH.
- RTYPEEX: `alusrca`=1, `alusrcb`=00, `alucontrol` from funct:
  - 100000/100001 ADD; 100010/100011 SUB.
  - 100100 AND; 100101 OR; 100110 XOR.
  - 101010/101011 SLT.
  - Next RTYPEWB. Unknown funct -> FETCH with no writeback.
- RTYPEWB: `regdst`=1, `memtoreg`=0, `regwrite`=1; next FETCH.
- BREX: `alusrca`=1, `alusrcb`=00, SUB, `pcsrc`=01, `branch`=1 (bne inverts `zero`); next FETCH.
- IMMEX: `alusrca`=1, `alusrcb`=10; addi ADD, slti SLT, andi AND, ori OR, xori XOR. Next IMMWB.
- IMMWB: `regdst`=0, `memtoreg`=0, `regwrite`=1; next FETCH.
- JEX: `pcsrc`=10, `pcwrite`=1; next FETCH.
- Unlisted outputs are 0 in each state.

## Timing

- Reset: `rst_n` low forces state to FETCH immediately. While reset is asserted, all write enables (`irwrite`, `memwrite`, `regwrite`, `pcen`) are 0. Muxes take FETCH values; `alucontrol`=0010.
- Reset mid-instruction: the instruction is abandoned and no partial write occurs after assertion. Restart is from FETCH on the first edge after release.
- Cycle counts with `mem_ready` tied high:
  - lw 5; sw 4; R-type 4; immediate 4; branch 3; jump 3.
  - Each low `mem_ready` cycle in FETCH, MEMRD or MEMWR adds one cycle.
- `pcen` is combinational from state and `zero`. All other outputs are decoded from state, plus `op`/`funct` for `alucontrol`.
- `mem_ready` high outside FETCH, MEMRD and MEMWR is ignored.

## Structure

- Shared package holds:
  - state enum;
  - opcode and funct constants;
  - ALU code constants (AND, OR, ADD, SUB, SLT, XOR), shared with the ALU and its testbench.
- Sub-module `alu_dec`: combinational map from (state class, op, funct) to `alucontrol`. The FSM itself stays in `mc_control`.

## Test plan

- `rst_n` low mid-MEMWR -> `memwrite` drops to 0 at once. After release, `irwrite`=1 on the first cycle with `mem_ready`=1.
- add (op 000000, funct 100000) with `mem_ready`=1 -> states FETCH, DECODE, RTYPEEX (`alucontrol`=0010), RTYPEWB (`regwrite`=1, `regdst`=1). Total 4 cycles.
- lw with `mem_ready` low 3 cycles in MEMRD -> MEMRD held 4 cycles. `iord`=1 throughout, then MEMWB `regwrite`=1 and `memtoreg`=1.
- beq with `zero`=1 -> `pcen`=1, `pcsrc`=01 in BREX. bne with `zero`=1 -> `pcen`=0.
- slt funct 101010 -> `alucontrol`=1011. xori -> 0101. sub -> 1010.
- Undefined op 111111 -> DECODE to FETCH. No write enable asserted for the whole instruction.
